// File: rtl/stage_sequencer_mc.sv
// stage_sequencer_mc
// Multi-channel stage sequencer. It walks the stages held in the stage ROM and
// keeps game time from a centi-second tick. For each of NUM_CHANNELS object
// channels it schedules spawn pulses, using a next-time handshake with that
// channel's object ROM reader.
//
// Optional feature macro: STAGE_SEQ_LOOP_EN
//   defined   : the end of the game loops back to stage 0 (game_done pulses)
//   undefined : the end of the game parks in DONE (game_done held high)
//
// Ports
//   clk            : the only clock
//   reset          : asynchronous reset, active low
//   tick_centi     : 100 Hz single-cycle time enable
//   is_player_dead : level input; aborts the run
//   rom_req        : stage ROM fetch request for current_stage
//   rom_valid      : stage ROM data valid
//   rom_amount     : per-channel object count, channel k at [k*COUNT_W +: COUNT_W]
//   rom_wait_time  : pre-stage wait, multiplied by TIME_SCALE
//   rom_is_end     : the addressed stage does not exist
//   next_time      : per-channel next spawn time, channel k at [k*TIME_W +: TIME_W]
//   time_valid     : per-channel pulse meaning next_time[k] was updated
//   spawn          : per-channel fire pulse; also requests the next time
//   obj_index      : per-channel running object index
//   current_stage  : current stage index
//   current_time   : game time in centi-seconds (saturating)
//   state          : IDLE=0 FETCH=1 WAIT=2 ARM=3 RUN=4 DONE=5
//   reset_stage    : one-cycle pulse on abort or loop
//   game_done      : end-of-game indication
module stage_sequencer_mc #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned STAGE_W      = 8,
  parameter int unsigned TIME_W       = 30,
  parameter int unsigned INDEX_W      = 20,
  parameter int unsigned COUNT_W      = 10,
  parameter int unsigned LAST_STAGE   = 2,
  parameter int unsigned TIME_SCALE   = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tick_centi,
  input  logic                            is_player_dead,
  output logic                            rom_req,
  input  logic                            rom_valid,
  input  logic [NUM_CHANNELS*COUNT_W-1:0] rom_amount,
  input  logic [7:0]                      rom_wait_time,
  input  logic                            rom_is_end,
  input  logic [NUM_CHANNELS*TIME_W-1:0]  next_time,
  input  logic [NUM_CHANNELS-1:0]         time_valid,
  output logic [NUM_CHANNELS-1:0]         spawn,
  output logic [NUM_CHANNELS*INDEX_W-1:0] obj_index,
  output logic [STAGE_W-1:0]              current_stage,
  output logic [TIME_W-1:0]               current_time,
  output logic [2:0]                      state,
  output logic                            reset_stage,
  output logic                            game_done
);

`ifdef STAGE_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam int unsigned EXT_W = TIME_W + 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ARM   = 3'd3,
    ST_RUN   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [STAGE_W-1:0]      stage_q;
  logic [TIME_W-1:0]       time_q;
  logic [TIME_W-1:0]       deadline_q;
  logic [COUNT_W-1:0]      amount_q [NUM_CHANNELS];
  logic [COUNT_W-1:0]      count_q  [NUM_CHANNELS];
  logic [INDEX_W-1:0]      idx_q    [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] ready_q;
  logic [NUM_CHANNELS-1:0] spawn_q;
  logic                    rom_req_q;
  logic                    reset_stage_q;
  logic                    game_done_q;
  logic                    dead_q;

  logic [NUM_CHANNELS-1:0] fire;
  logic [NUM_CHANNELS-1:0] done;
  logic                    abort;
  logic                    latch;
  logic                    arm;
  logic                    step_stage;
  logic                    end_act;
  logic                    loop_clear;
  logic [EXT_W-1:0]        deadline_ext;
  logic [TIME_W-1:0]       deadline_sat;

  // Deadline is formed wide so a late fetch near the top of the time range
  // saturates instead of wrapping to an early deadline.
  assign deadline_ext = EXT_W'(time_q) + EXT_W'(rom_wait_time) * EXT_W'(TIME_SCALE);
  assign deadline_sat = (|deadline_ext[EXT_W-1:TIME_W]) ? '1 : deadline_ext[TIME_W-1:0];

  always_comb begin
    abort = is_player_dead &&
            ((state_q == ST_FETCH) || (state_q == ST_WAIT) ||
             (state_q == ST_ARM)   || (state_q == ST_RUN));
    fire = '0;
    done = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      done[k] = (count_q[k] == amount_q[k]);
      fire[k] = (state_q == ST_RUN) && !abort && ready_q[k] &&
                (count_q[k] < amount_q[k]) &&
                (time_q >= next_time[k*TIME_W +: TIME_W]);
    end
  end

  always_comb begin
    state_d    = state_q;
    latch      = 1'b0;
    arm        = 1'b0;
    step_stage = 1'b0;
    end_act    = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (abort) begin
          state_d = ST_FETCH;
        end else if (rom_valid) begin
          if (rom_is_end) begin
            end_act = 1'b1;
          end else begin
            latch   = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (abort)                     state_d = ST_FETCH;
        else if (time_q >= deadline_q) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (abort) begin
          state_d = ST_FETCH;
        end else begin
          arm     = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_FETCH;
        end else if (&done) begin
          if (stage_q == STAGE_W'(LAST_STAGE - 1)) begin
            end_act = 1'b1;
          end else begin
            step_stage = 1'b1;
            state_d    = ST_FETCH;
          end
        end
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    if (end_act) state_d = LOOP_EN ? ST_FETCH : ST_DONE;
  end

  assign loop_clear = end_act && LOOP_EN;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q       <= '0;
      time_q        <= '0;
      deadline_q    <= '0;
      ready_q       <= '0;
      spawn_q       <= '0;
      rom_req_q     <= 1'b0;
      reset_stage_q <= 1'b0;
      game_done_q   <= 1'b0;
      dead_q        <= 1'b0;
      for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
        amount_q[k] <= '0;
        count_q[k]  <= '0;
        idx_q[k]    <= '0;
      end
    end else begin
      if (tick_centi && (time_q != '1)) time_q <= time_q + TIME_W'(1);

      dead_q <= is_player_dead;
      // Request rises on the second FETCH cycle and drops once data is taken
      // or while the player is dead.
      rom_req_q     <= (state_q == ST_FETCH) && (state_d == ST_FETCH) && !is_player_dead;
      // A held dead level produces a single reset_stage pulse.
      reset_stage_q <= (abort && !dead_q) || loop_clear;
      game_done_q   <= LOOP_EN ? end_act : (state_d == ST_DONE);

      if (latch) deadline_q <= deadline_sat;

      if (abort || loop_clear) stage_q <= '0;
      else if (step_stage)     stage_q <= stage_q + STAGE_W'(1);

      for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
        spawn_q[k] <= 1'b0;
        if (latch) amount_q[k] <= rom_amount[k*COUNT_W +: COUNT_W];
        if (abort || loop_clear) begin
          count_q[k] <= '0;
          ready_q[k] <= 1'b0;
          idx_q[k]   <= '0;
        end else if (arm) begin
          count_q[k] <= '0;
          ready_q[k] <= 1'b0;
          spawn_q[k] <= (amount_q[k] != '0);
        end else if (fire[k]) begin
          spawn_q[k] <= 1'b1;
          idx_q[k]   <= idx_q[k] + INDEX_W'(1);
          count_q[k] <= count_q[k] + COUNT_W'(1);
          ready_q[k] <= 1'b0;
        end else if ((state_q == ST_RUN) && time_valid[k] && !ready_q[k]) begin
          ready_q[k] <= 1'b1;
        end
      end
    end
  end

  assign rom_req       = rom_req_q;
  assign spawn         = spawn_q;
  assign current_stage = stage_q;
  assign current_time  = time_q;
  assign state         = state_q;
  assign reset_stage   = reset_stage_q;
  assign game_done     = game_done_q;

  always_comb begin
    obj_index = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++)
      obj_index[k*INDEX_W +: INDEX_W] = idx_q[k];
  end

endmodule

// File: tb/tb_stage_sequencer_mc.sv
// tb_stage_sequencer_mc
// Bench for stage_sequencer_mc with the default 4-channel, 2-stage setup.
// Models the stage ROM (a two-entry stage table) and the channel readers
// (answer every spawn with time_valid one cycle later). Table scenarios,
// directed corner sequences and randomized runs are checked against totals
// computed from the stage table.
module tb_stage_sequencer_mc;

  localparam int NCH = 4;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ARM   = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic         clk = 1'b0;
  logic         reset;
  logic         tick_centi;
  logic         is_player_dead;
  logic         rom_req;
  logic         rom_valid;
  logic [39:0]  rom_amount;
  logic [7:0]   rom_wait_time;
  logic         rom_is_end;
  logic [119:0] next_time;
  logic [3:0]   time_valid;
  logic [3:0]   spawn;
  logic [79:0]  obj_index;
  logic [7:0]   current_stage;
  logic [29:0]  current_time;
  logic [2:0]   state;
  logic         reset_stage;
  logic         game_done;

  stage_sequencer_mc #(
    .NUM_CHANNELS(4), .STAGE_W(8), .TIME_W(30), .INDEX_W(20),
    .COUNT_W(10), .LAST_STAGE(2), .TIME_SCALE(10)
  ) dut (
    .clk(clk), .reset(reset), .tick_centi(tick_centi),
    .is_player_dead(is_player_dead), .rom_req(rom_req), .rom_valid(rom_valid),
    .rom_amount(rom_amount), .rom_wait_time(rom_wait_time), .rom_is_end(rom_is_end),
    .next_time(next_time), .time_valid(time_valid), .spawn(spawn),
    .obj_index(obj_index), .current_stage(current_stage), .current_time(current_time),
    .state(state), .reset_stage(reset_stage), .game_done(game_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][9:0] amt0;
    logic [3:0][9:0] amt1;
    logic [7:0]      w0;
    logic [7:0]      w1;
    bit              end1;
    int unsigned     nt;
    logic [3:0][7:0] exp_fire;
  } vec_t;

  vec_t vecs [4];

  int checks = 0;
  int errors = 0;

  // environment
  bit              auto_rom, auto_chan, rand_tick, rand_nt;
  logic [3:0][9:0] tab_amt [2];
  logic [7:0]      tab_wait [2];
  bit              tab_end1;
  int unsigned     nt_fixed;

  // monitor state
  int unsigned  fires [NCH];
  int unsigned  arm_sp [NCH];
  logic [2:0]   prev_state;
  logic [7:0]   prev_stage;
  logic [29:0]  prev_time;
  logic [63:0]  exp_deadline;
  bit           end_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_ge(input string name, input logic [63:0] act, input logic [63:0] bound);
    checks++;
    if (!(act >= bound)) begin
      errors++;
      $display("FAIL %s: got %0d required >= %0d at %0t", name, act, bound, $time);
    end
  endtask

  task automatic step();
    logic [63:0] d;
    @(posedge clk);
    #1;
    for (int k = 0; k < NCH; k++) begin
      if (spawn[k] === 1'b1) begin
        if (prev_state == ST_ARM) arm_sp[k]++;
        else begin
          fires[k]++;
          check_ge("fire_time", 64'(prev_time), 64'(next_time[k*30 +: 30]));
        end
      end
    end
    if (state == ST_ARM && prev_state == ST_WAIT)
      check_ge("arm_deadline", 64'(prev_time), exp_deadline);
    if (state == ST_FETCH && prev_state == ST_RUN && !game_done && !reset_stage)
      check("stage_step", 64'(current_stage), 64'(prev_stage) + 64'd1);
`ifdef STAGE_SEQ_LOOP_EN
    if (game_done === 1'b1) end_seen = 1'b1;
`else
    if (state == ST_DONE) end_seen = 1'b1;
`endif
    prev_state = state;
    prev_stage = current_stage;
    prev_time  = current_time;

    if (auto_rom) begin
      rom_valid = rom_req;
      if (current_stage < 8'd2) begin
        rom_amount    = tab_amt[current_stage[0]];
        rom_wait_time = tab_wait[current_stage[0]];
        rom_is_end    = (current_stage == 8'd1) && tab_end1;
      end else begin
        rom_amount    = '0;
        rom_wait_time = '0;
        rom_is_end    = 1'b1;
      end
      if (rom_valid && !rom_is_end) begin
        d = 64'(current_time) + 64'(rom_wait_time) * 64'd10;
        exp_deadline = (d > 64'h3FFF_FFFF) ? 64'h3FFF_FFFF : d;
      end
    end
    if (auto_chan) begin
      time_valid = spawn;
      for (int k = 0; k < NCH; k++)
        if (spawn[k])
          next_time[k*30 +: 30] = rand_nt ? current_time + 30'($urandom_range(0, 6))
                                          : 30'(nt_fixed);
    end
    if (rand_tick) tick_centi = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    is_player_dead = 1'b0;
    rom_valid = 1'b0;
    rom_amount = '0;
    rom_wait_time = '0;
    rom_is_end = 1'b0;
    next_time = '0;
    time_valid = '0;
    tick_centi = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      fires[k] = 0;
      arm_sp[k] = 0;
    end
    end_seen = 1'b0;
    exp_deadline = '0;
    @(posedge clk);
    #1;
    check("rst_state", 64'(state), 64'(ST_IDLE));
    check("rst_time", 64'(current_time), 64'd0);
    check("rst_outs", 64'({spawn, rom_req, reset_stage, game_done, current_stage}), 64'd0);
    check("rst_idx", 64'(obj_index), 64'd0);
    reset = 1'b1;
    prev_state = ST_IDLE;
    prev_stage = '0;
    prev_time = '0;
    step();
    check("idle_to_fetch", 64'(state), 64'(ST_FETCH));
  endtask

  task automatic run_until_end(input int budget);
    int n = 0;
    while (!end_seen && n < budget) begin
      step();
      n++;
    end
    if (!end_seen) check("end_timeout", 64'd0, 64'd1);
  endtask

  // Totals derived from the stage table: each channel fires its amount per
  // completed stage, gets one initial request per stage with a non-zero amount.
  task automatic score(input logic [3:0][7:0] exp_fire);
    for (int k = 0; k < NCH; k++) begin
      int unsigned ea;
      ea = ((tab_amt[0][k] != 0) ? 1 : 0) + ((!tab_end1 && tab_amt[1][k] != 0) ? 1 : 0);
      check("fire_count", 64'(fires[k]), 64'(exp_fire[k]));
      check("arm_spawns", 64'(arm_sp[k]), 64'(ea));
`ifdef STAGE_SEQ_LOOP_EN
      check("end_idx", 64'(obj_index[k*20 +: 20]), 64'd0);
`else
      check("end_idx", 64'(obj_index[k*20 +: 20]), 64'(exp_fire[k]));
`endif
    end
`ifdef STAGE_SEQ_LOOP_EN
    check("loop_end", 64'({state, current_stage, reset_stage}), 64'({ST_FETCH, 8'd0, 1'b1}));
`else
    check("done_end", 64'({state, game_done}), 64'({ST_DONE, 1'b1}));
    auto_chan = 1'b0;
    is_player_dead = 1'b1;
    time_valid = '1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("done_hold", 64'({state, game_done, spawn}), 64'({ST_DONE, 1'b1, 4'b0}));
    end
    is_player_dead = 1'b0;
    time_valid = '0;
    auto_chan = 1'b1;
`endif
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0][7:0] ef;

    // ch3..ch0 order in every packed literal below
    vecs[0].amt0 = {10'd0, 10'd0, 10'd2, 10'd3};  vecs[0].amt1 = {10'd1, 10'd0, 10'd0, 10'd1};
    vecs[0].w0 = 8'd0; vecs[0].w1 = 8'd0; vecs[0].end1 = 1'b0; vecs[0].nt = 5;
    vecs[0].exp_fire = {8'd1, 8'd0, 8'd2, 8'd4};
    vecs[1].amt0 = '0; vecs[1].amt1 = '0;
    vecs[1].w0 = 8'd0; vecs[1].w1 = 8'd1; vecs[1].end1 = 1'b0; vecs[1].nt = 0;
    vecs[1].exp_fire = '0;
    vecs[2].amt0 = {10'd1, 10'd1, 10'd1, 10'd1};  vecs[2].amt1 = {10'd5, 10'd5, 10'd5, 10'd5};
    vecs[2].w0 = 8'd1; vecs[2].w1 = 8'd0; vecs[2].end1 = 1'b1; vecs[2].nt = 0;
    vecs[2].exp_fire = {8'd1, 8'd1, 8'd1, 8'd1};
    vecs[3].amt0 = {10'd1, 10'd3, 10'd0, 10'd2};  vecs[3].amt1 = {10'd2, 10'd0, 10'd4, 10'd0};
    vecs[3].w0 = 8'd2; vecs[3].w1 = 8'd0; vecs[3].end1 = 1'b0; vecs[3].nt = 30;
    vecs[3].exp_fire = {8'd3, 8'd3, 8'd4, 8'd2};

    auto_rom = 1'b1; auto_chan = 1'b1; rand_tick = 1'b0; rand_nt = 1'b0;

    // table-driven scenarios
    for (int i = 0; i < 4; i++) begin
      tab_amt[0] = vecs[i].amt0; tab_amt[1] = vecs[i].amt1;
      tab_wait[0] = vecs[i].w0;  tab_wait[1] = vecs[i].w1;
      tab_end1 = vecs[i].end1;   nt_fixed = vecs[i].nt;
      do_reset();
      tick_centi = 1'b1;
      run_until_end(3000);
      score(vecs[i].exp_fire);
    end

    // wait=7 latched at time 100: ARM must first appear once time reaches 170
    auto_rom = 1'b0;
    tab_amt[0] = '0; tab_amt[1] = '0; tab_end1 = 1'b0;
    do_reset();
    tick_centi = 1'b1;
    n = 0;
    while (current_time != 30'd100 && n < 400) begin step(); n++; end
    check("reach_t100", 64'(current_time), 64'd100);
    tick_centi = 1'b0;
    rom_valid = 1'b1;
    rom_amount = {10'd0, 10'd0, 10'd0, 10'd1};
    rom_wait_time = 8'd7;
    rom_is_end = 1'b0;
    exp_deadline = 64'd170;
    step();
    check("latched_wait", 64'({state, current_time}), 64'({ST_WAIT, 30'd100}));
    rom_valid = 1'b0;
    tick_centi = 1'b1;
    n = 0;
    while (state != ST_ARM && n < 200) begin step(); n++; end
    check("arm_at_170", 64'({state, current_time}), 64'({ST_ARM, 30'd171}));

    // zero-amount stage 0, then abort coinciding with a ch0 fire in stage 1
    auto_rom = 1'b1;
    tab_amt[0] = '0; tab_amt[1] = {10'd0, 10'd0, 10'd0, 10'd2};
    tab_wait[0] = 8'd0; tab_wait[1] = 8'd0; tab_end1 = 1'b0; nt_fixed = 5;
    do_reset();
    tick_centi = 1'b1;
    n = 0;
    while (state != ST_ARM && n < 100) begin step(); n++; end
    check("zero_arm", 64'({state, spawn}), 64'({ST_ARM, 4'b0}));
    step();
    check("zero_run", 64'({state, spawn}), 64'({ST_RUN, 4'b0}));
    step();
    check("zero_step", 64'({state, current_stage, spawn}), 64'({ST_FETCH, 8'd1, 4'b0}));
    n = 0;
    while (!(state == ST_RUN && spawn[0]) && n < 100) begin step(); n++; end
    check("s1_arm_spawn", 64'({state, current_stage, spawn}), 64'({ST_RUN, 8'd1, 4'b0001}));
    step();
    is_player_dead = 1'b1;
    step();
    check("abort_nofire", 64'(spawn), 64'd0);
    check("abort_pulse", 64'({reset_stage, state, current_stage}), 64'({1'b1, ST_FETCH, 8'd0}));
    check("abort_idx", 64'(obj_index), 64'd0);
    step();
    check("dead_hold", 64'({state, rom_req, reset_stage}), 64'({ST_FETCH, 1'b0, 1'b0}));
    is_player_dead = 1'b0;

    // asynchronous reset between clock edges while running
    tab_amt[0] = {10'd0, 10'd0, 10'd2, 10'd3}; tab_amt[1] = '0;
    do_reset();
    tick_centi = 1'b1;
    n = 0;
    while (!(state == ST_RUN && obj_index[19:0] != 0) && n < 300) begin step(); n++; end
    check("mid_run", 64'(state), 64'(ST_RUN));
    #3;
    reset = 1'b0;
    #1;
    check("async_state", 64'(state), 64'(ST_IDLE));
    check("async_outs", 64'({spawn, rom_req, reset_stage, game_done, current_stage, current_time}), 64'd0);
    check("async_idx", 64'(obj_index), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    prev_state = ST_IDLE;
    step();
    check("async_release", 64'(state), 64'(ST_FETCH));

    // randomized runs scored against table totals
    rand_tick = 1'b1;
    rand_nt = 1'b1;
    for (int r = 0; r < 12; r++) begin
      for (int s = 0; s < 2; s++) begin
        for (int k = 0; k < NCH; k++) tab_amt[s][k] = 10'($urandom_range(0, 3));
        tab_wait[s] = 8'($urandom_range(0, 3));
      end
      tab_end1 = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < NCH; k++)
        ef[k] = 8'(tab_amt[0][k]) + (tab_end1 ? 8'd0 : 8'(tab_amt[1][k]));
      do_reset();
      run_until_end(4000);
      score(ef);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_sequencer_mc.md
# stage_sequencer_mc

Multi-channel stage sequencer: steps the game through stages read from the stage ROM, keeps game time from a centi-second tick, and schedules spawn events for `NUM_CHANNELS` independent object channels (attack, platform, and others) using a per-channel next-time handshake. It sits between the stage ROM reader and the per-channel object ROM readers, and generalises the two-channel runtime. Added behaviour: a stage completes only when every channel is done, zero-amount channels are allowed, time saturates, and end-of-game either loops or halts.

## Interface
- `NUM_CHANNELS`, 4: number of spawn channels.
- `STAGE_W`, 8: stage index width.
- `TIME_W`, 30: time width, in centi-second units.
- `INDEX_W`, 20: per-channel object index width.
- `COUNT_W`, 10: per-channel per-stage amount width.
- `LAST_STAGE`, 2: number of stages; completing stage `LAST_STAGE-1` ends the game.
- `TIME_SCALE`, 10: multiplier applied to `rom_wait_time`.
- `clk` in 1: the only clock.
- `reset` in 1: asynchronous, active-low.
- `tick_centi` in 1: single-cycle enable at 100 Hz.
- `is_player_dead` in 1: level; aborts the run.
- `rom_req` out 1: stage ROM fetch request for `current_stage`.
- `rom_valid` in 1: stage ROM data valid.
- `rom_amount` in NUM_CHANNELS*COUNT_W: amount per channel; channel k is `[k*COUNT_W +: COUNT_W]`.
- `rom_wait_time` in 8: pre-stage wait, scaled by `TIME_SCALE`.
- `rom_is_end` in 1: addressed stage does not exist.
- `next_time` in NUM_CHANNELS*TIME_W: next spawn time per channel.
- `time_valid` in NUM_CHANNELS: per-channel pulse meaning `next_time[k]` is updated.
- `spawn` out NUM_CHANNELS: per-channel fire pulse; also requests the next time.
- `obj_index` out NUM_CHANNELS*INDEX_W: per-channel object index.
- `current_stage` out STAGE_W: current stage index.
- `current_time` out TIME_W: game time.
- `state` out 3: IDLE=0, FETCH=1, WAIT=2, ARM=3, RUN=4, DONE=5.
- `reset_stage` out 1: one-cycle pulse on abort or loop.
- `game_done` out 1: end-of-game indication; see Configuration.

## Operation
- Reset (`reset`=0, async): state IDLE. All of the following are 0: `current_stage`, `current_time`, `obj_index`, counts, deadline, `spawn`, `rom_req`, `reset_stage`, `game_done`. All channel ready flags are 0.
- IDLE: moves to FETCH on the first clock after reset deasserts.
- FETCH: `rom_req`=1 (registered).
  - When `rom_valid`=1 and `rom_is_end`=0: latch amounts and wait, set deadline = `current_time` + `rom_wait_time`*`TIME_SCALE`, then go to WAIT. The deadline is computed at TIME_W+4 bits and saturates to all-ones.
  - When `rom_valid`=1 and `rom_is_end`=1: take the end action.
- WAIT: when `current_time` >= deadline (unsigned), go to ARM.
- ARM (one cycle): for every channel, clear the count and clear the ready flag. Pulse `spawn[k]` only for channels with amount > 0; this pulse is the initial next-time request and does not increment `obj_index`. Then go to RUN.
- RUN, per channel k:
  - `time_valid[k]` while ready=0 sets ready=1 on the next cycle. `time_valid[k]` while ready=1 is ignored.
  - Fire condition: ready=1, count<amount, and `current_time` >= `next_time[k]`. On fire: pulse `spawn[k]` for one cycle, then `obj_index[k]`+1, count+1, ready=0.
  - A channel is done when count==amount. A channel with amount 0 is done in ARM.
  - Channels operate independently. Multiple channels may fire in the same cycle.
- Stage completion: when all channels are done, `current_stage`+1 and go to FETCH. If the completed stage was `LAST_STAGE-1`, take the end action instead.
- `obj_index` is not cleared between stages; it is a running index into the object ROMs. It wraps at 2^INDEX_W.
- `is_player_dead`=1 in FETCH, WAIT, ARM, or RUN aborts the run:
  - `current_stage`=0, `obj_index`=0, counts=0, ready=0.
  - `reset_stage` pulses; go to FETCH with no wait.
  - Abort takes priority over firing and over stage completion in the same cycle.
  - While `is_player_dead` stays high, the state is held in FETCH with `rom_req`=0.
- `current_time`: +1 on each `tick_centi`; saturates at all-ones. It is never cleared except by `reset`.

## Timing
- Fetch: `rom_req` rises 1 cycle after entering FETCH. Data is latched in the cycle `rom_valid`=1. The FSM is in WAIT the next cycle.
- WAIT with wait=0: exactly 1 cycle, then ARM, then RUN.
- Fire: `spawn[k]` is asserted the cycle after the fire condition holds. `obj_index` updates in that same cycle.
- Spawn spacing: the earliest re-fire is 1 cycle after `time_valid[k]`. The minimum spacing is therefore 2 cycles plus the channel module's latency.
- Stage step: FETCH is entered 1 cycle after the last channel is done.

## Configuration
- `STAGE_SEQ_LOOP_EN` defined:
  - The end action sets `current_stage`=0 and `obj_index`=0, pulses `reset_stage`, pulses `game_done` for one cycle, and goes to FETCH.
- `STAGE_SEQ_LOOP_EN` undefined:
  - The end action goes to DONE. `game_done`=1 and `spawn`=0 are held until `reset`.
  - `is_player_dead` is ignored in DONE.

## Test plan
- Stage with amounts {3,2,0,0}, wait=0, next_time=5 for all channels, `time_valid` one cycle after each spawn. Required: exactly 3 spawn pulses on ch0 and 2 on ch1, each at `current_time`>=5; `obj_index` ends at {3,2,0,0}; then FETCH with stage 1.
- Wait=7, `TIME_SCALE`=10, `rom_valid` at `current_time`=100. Required: ARM occurs when `current_time` first reaches 170, not earlier.
- All amounts 0 in stage 0. Required: sequence ARM→RUN→FETCH, with stage=1, no fire pulses, and ARM `spawn` pulses suppressed.
- `is_player_dead` pulsed during RUN in stage 1, in the same cycle as a ch0 fire condition. Required: no fire, `reset_stage` pulse, stage=0, `obj_index`=0, FETCH.
- Completing stage 1 with `LAST_STAGE`=2:
  - With the macro defined: `game_done` pulse, stage=0, FETCH.
  - Without the macro: DONE, `game_done`=1 held, `spawn` stays 0.
- `reset` asserted low mid-RUN, asynchronously between clock edges. Required: all outputs are 0 immediately and state=IDLE.
